// File: rtl/hog_pkg.sv
// rtl/hog_pkg.sv - shared pixel and frame geometry constants for the HOG/SVM pipeline
// Contents: default pixel width, packed word width and 160x120 frame geometry.
package hog_pkg;
  localparam int HOG_PIX_W     = 8;
  localparam int HOG_IN_W      = HOG_PIX_W * 4;
  localparam int HOG_FRAME_W   = 160;
  localparam int HOG_FRAME_H   = 120;
  localparam int HOG_FRAME_PIX = HOG_FRAME_W * HOG_FRAME_H;
endpackage

// File: rtl/hog_pixel_feeder_if.sv
// rtl/hog_pixel_feeder_if.sv - camera pixel input and HOG word output handshake bundle
// Signals: pix_valid/pix_data/sof (camera side), request (HOG pull),
//          ready/o_data (head of the packed word FIFO).
// Modports: master = camera + HOG consumer side, slave = feeder side.
interface hog_pixel_feeder_if #(
  parameter int PIX_W = 8
) ();
  logic               pix_valid;
  logic [PIX_W-1:0]   pix_data;
  logic               sof;
  logic               request;
  logic               ready;
  logic [PIX_W*4-1:0] o_data;

  modport master (output pix_valid, output pix_data, output sof, output request,
                  input ready, input o_data);
  modport slave  (input pix_valid, input pix_data, input sof, input request,
                  output ready, output o_data);
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO
// Ports: clk, rst (async active-low), push/din write side, pop/dout read side,
//        empty, full, level (occupancy, PTR_W+1 bits).
// dout shows the head word combinationally and reads as zero while empty.
module sync_fifo_fwft #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [DW-1:0]  din,
  input  logic           pop,
  output logic [DW-1:0]  dout,
  output logic           empty,
  output logic           full,
  output logic [PTR_W:0] level
);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);
  assign level = level_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/hog_pixel_feeder.sv
// rtl/hog_pixel_feeder.sv - packs 4 camera pixels per word into a FWFT FIFO for the HOG block
// Ports: clk, rst (async active-low), bus (slave: pixel in, request/ready/o_data out),
//        frame_end (1-cycle pulse after the last word of a frame is pushed),
//        overflow (sticky drop), sof_err (sticky bad sof), level (FIFO occupancy).
module hog_pixel_feeder
  import hog_pkg::*;
#(
  parameter  int PIX_W       = HOG_PIX_W,
  parameter  int DEPTH       = 16,
  parameter  int FRAME_PIX   = HOG_FRAME_PIX,
  localparam int OUT_W       = PIX_W * 4,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int FRAME_WORDS = FRAME_PIX / 4,
  localparam int CNT_W       = $clog2(FRAME_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  hog_pixel_feeder_if.slave     bus,
  output logic                  frame_end,
  output logic                  overflow,
  output logic                  sof_err,
  output logic [PTR_W:0]        level
);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_WORDS - 1);

  logic [1:0]            lane_q, lane_d, eff_lane;
  logic [2:0][PIX_W-1:0] lanes_q, lanes_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d, cnt_base;
  logic                  frame_end_q, frame_end_d;
  logic                  overflow_q, overflow_d;
  logic                  sof_err_q, sof_err_d;
  logic                  push, pop, fifo_empty, fifo_full;
  logic [OUT_W-1:0]      push_word;

  assign pop       = bus.request && !fifo_empty;
  assign bus.ready = !fifo_empty;
  assign frame_end = frame_end_q;
  assign overflow  = overflow_q;
  assign sof_err   = sof_err_q;

  always_comb begin
    lane_d      = lane_q;
    lanes_d     = lanes_q;
    frame_cnt_d = frame_cnt_q;
    frame_end_d = 1'b0;
    overflow_d  = overflow_q;
    sof_err_d   = sof_err_q;
    eff_lane    = lane_q;
    cnt_base    = frame_cnt_q;
    push        = 1'b0;
    push_word   = {bus.pix_data, lanes_q};

    if (bus.pix_valid) begin
      // sof restarts packing at lane 0; leftover lanes or an unfinished frame are an error.
      if (bus.sof) begin
        if ((lane_q != 2'd0) || (frame_cnt_q != '0)) sof_err_d = 1'b1;
        eff_lane = 2'd0;
        cnt_base = '0;
      end
      case (eff_lane)
        2'd0:    lanes_d[0] = bus.pix_data;
        2'd1:    lanes_d[1] = bus.pix_data;
        2'd2:    lanes_d[2] = bus.pix_data;
        default: push = 1'b1;
      endcase
      if (push) begin
        lane_d = 2'd0;
        // Dropped words still count toward the frame so frame_end stays aligned.
        if (cnt_base == FRAME_LAST) begin
          frame_cnt_d = '0;
          frame_end_d = 1'b1;
        end else begin
          frame_cnt_d = cnt_base + 1'b1;
        end
      end else begin
        lane_d      = eff_lane + 2'd1;
        frame_cnt_d = cnt_base;
      end
    end

    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q      <= '0;
      lanes_q     <= '0;
      frame_cnt_q <= '0;
      frame_end_q <= 1'b0;
      overflow_q  <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      lanes_q     <= lanes_d;
      frame_cnt_q <= frame_cnt_d;
      frame_end_q <= frame_end_d;
      overflow_q  <= overflow_d;
      sof_err_q   <= sof_err_d;
    end
  end

  sync_fifo_fwft #(
    .DW    (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (bus.o_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );
endmodule

// File: tb/tb_hog_pixel_feeder.sv
// tb/tb_hog_pixel_feeder.sv - self-checking bench for hog_pixel_feeder against a queue model
module tb_hog_pixel_feeder;
  localparam int PIX_W     = 8;
  localparam int DEPTH     = 16;
  localparam int FRAME_PIX = 16;
  localparam int FW        = FRAME_PIX / 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_end, overflow, sof_err;
  logic [4:0] level;

  hog_pixel_feeder_if #(.PIX_W(PIX_W)) bus ();

  hog_pixel_feeder #(
    .PIX_W     (PIX_W),
    .DEPTH     (DEPTH),
    .FRAME_PIX (FRAME_PIX)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_end (frame_end),
    .overflow  (overflow),
    .sof_err   (sof_err),
    .level     (level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  logic [7:0]  pend[$];
  int          fcnt;
  bit          m_ovf, m_serr, m_fe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pend.delete();
    fcnt = 0; m_ovf = 0; m_serr = 0; m_fe = 0;
  endtask

  // Pop happens before the pixel is considered, so a full FIFO with a pop has room.
  task automatic model_step(input bit v, input logic [7:0] d, input bit s, input bit r);
    logic [31:0] w;
    m_fe = 0;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (v) begin
      if (s) begin
        if (pend.size() != 0 || fcnt != 0) m_serr = 1;
        pend.delete();
        fcnt = 0;
      end
      pend.push_back(d);
      if (pend.size() == 4) begin
        w = {pend[3], pend[2], pend[1], pend[0]};
        pend.delete();
        fcnt++;
        if (fcnt == FW) begin fcnt = 0; m_fe = 1; end
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] head;
    head = (mq.size() > 0) ? mq[0] : 32'h0;
    check({tag, ".ready"},     {31'h0, bus.ready}, {31'h0, mq.size() > 0});
    check({tag, ".level"},     {27'h0, level},     mq.size());
    check({tag, ".o_data"},    bus.o_data,         head);
    check({tag, ".frame_end"}, {31'h0, frame_end}, {31'h0, m_fe});
    check({tag, ".overflow"},  {31'h0, overflow},  {31'h0, m_ovf});
    check({tag, ".sof_err"},   {31'h0, sof_err},   {31'h0, m_serr});
  endtask

  // Called at posedge+1; inputs change away from the edge, outputs sampled 1 after the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit s, input bit r, input string tag);
    bus.pix_valid = v; bus.pix_data = d; bus.sof = s; bus.request = r;
    model_step(v, d, s, r);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #3 rst = 1'b0;
    #1;
    check({tag, ".rst_ready"},     {31'h0, bus.ready}, 32'h0);
    check({tag, ".rst_o_data"},    bus.o_data,         32'h0);
    check({tag, ".rst_level"},     {27'h0, level},     32'h0);
    check({tag, ".rst_frame_end"}, {31'h0, frame_end}, 32'h0);
    check({tag, ".rst_overflow"},  {31'h0, overflow},  32'h0);
    check({tag, ".rst_sof_err"},   {31'h0, sof_err},   32'h0);
    bus.pix_valid = 0; bus.pix_data = 0; bus.sof = 0; bus.request = 0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all({tag, ".post_rst"});
  endtask

  initial begin
    int fe_cnt;
    int n;
    bus.pix_valid = 0; bus.pix_data = 0; bus.sof = 0; bus.request = 0;
    model_clear();
    @(posedge clk); #1;

    // 1: first word and its latency
    do_reset("t1");
    step(1, 8'h11, 1, 0, "t1");
    step(1, 8'h22, 0, 0, "t1");
    step(1, 8'h33, 0, 0, "t1");
    step(1, 8'h44, 0, 0, "t1");
    check("t1.word",  bus.o_data, 32'h44332211);
    check("t1.ready", {31'h0, bus.ready}, 32'h1);
    check("t1.level", {27'h0, level}, 32'h1);

    // 2: overfill with random pixels, then drain
    do_reset("t2");
    for (int i = 0; i < 80; i++) begin
      step(1, 8'($urandom), i == 0, 0, "t2_fill");
      if (i == 63) check("t2.no_ovf_at16", {31'h0, overflow}, 32'h0);
      if (i == 67) check("t2.ovf_at17", {31'h0, overflow}, 32'h1);
    end
    check("t2.level_full", {27'h0, level}, 32'd16);
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      step(0, 8'h00, 0, 1, "t2_drain");
      n++;
    end
    check("t2.drain_bound", n, 32'd16);
    step(0, 8'h00, 0, 1, "t2_idle");
    check("t2.ready_low", {31'h0, bus.ready}, 32'h0);

    // 3: full FIFO accepts a push when popped in the same cycle
    do_reset("t3");
    for (int i = 0; i < 64; i++) step(1, 8'($urandom), i == 0, 0, "t3_fill");
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0, "t3_part");
    step(1, 8'($urandom), 0, 1, "t3_pushpop");
    check("t3.level", {27'h0, level}, 32'd16);
    check("t3.ovf",   {31'h0, overflow}, 32'h0);

    // 4: sof in the middle of a word
    do_reset("t4");
    for (int i = 0; i < 6; i++) step(1, 8'(i + 1), i == 0, 0, "t4_pre");
    step(1, 8'hAA, 1, 0, "t4_sof");
    for (int i = 0; i < 3; i++) step(1, 8'(8'hB0 + i), 0, 0, "t4_post");
    check("t4.sof_err", {31'h0, sof_err}, 32'h1);
    check("t4.level",   {27'h0, level}, 32'd2);
    check("t4.word1",   bus.o_data, 32'h04030201);
    step(0, 8'h00, 0, 1, "t4_pop");
    check("t4.word2",   bus.o_data, 32'hB2B1B0AA);

    // 5: frame boundary pulse and implicit next frame
    do_reset("t5");
    fe_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 8'($urandom), i == 0, 1, "t5_frame");
      if (frame_end) fe_cnt++;
    end
    check("t5.fe_last", {31'h0, frame_end}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'($urandom), 0, 1, "t5_next");
      if (frame_end) fe_cnt++;
    end
    check("t5.fe_count", fe_cnt, 32'd1);
    check("t5.no_sof_err", {31'h0, sof_err}, 32'h0);

    // 6: reset mid-stream with level=5 and lane=2
    do_reset("t6");
    for (int i = 0; i < 22; i++) step(1, 8'($urandom), i == 0, 0, "t6_fill");
    check("t6.level5", {27'h0, level}, 32'd5);
    do_reset("t6_mid");
    step(1, 8'h01, 0, 0, "t6_after");
    step(1, 8'h02, 0, 0, "t6_after");
    step(1, 8'h03, 0, 0, "t6_after");
    step(1, 8'h04, 0, 0, "t6_after");
    check("t6.aligned", bus.o_data, 32'h04030201);

    // 7: random traffic
    do_reset("t7");
    for (int i = 0; i < 400; i++) begin
      bit v, s, r;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 2) == 0);
      step(v, 8'($urandom), s, r, "t7_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hog_pixel_feeder.md
Name: hog_pixel_feeder

Overview:
Upstream stage of the HOG/SVM pipeline. It accepts a camera pixel stream at one pixel per cycle and packs each group of 4 consecutive pixels into a 32-bit word. Packed words are buffered in a first-word-fall-through (FWFT) FIFO, which drives the HOG input interface: ready/data into the HOG block, request coming back. It also tracks frame boundaries and flags dropped data.

Parameters:
PIX_W, 8, pixel width in bits
DEPTH, 16, FIFO depth in packed words (power of 2)
FRAME_PIX, 19200, pixels per frame (160x120); must be a multiple of 4
localparam OUT_W = PIX_W*4, packed word width
localparam PTR_W = log2(DEPTH)
localparam CNT_W = width able to hold FRAME_PIX/4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
pix_valid  in  1  pixel strobe from camera
pix_data  in  PIX_W  pixel value
sof  in  1  start of frame; qualified by pix_valid, marks the first pixel of a frame
request  in  1  HOG consumer pull; a word transfers when request && ready
ready  out  1  head word valid (FIFO not empty)
o_data  out  OUT_W  head word of FIFO; first pixel of the group in bits [PIX_W-1:0]
frame_end  out  1  one-cycle pulse when the last word of a frame is pushed
overflow  out  1  sticky: a word was dropped because the FIFO was full
sof_err  out  1  sticky: sof arrived with a partial word pending or a frame not completed
level  out  PTR_W+1  current FIFO occupancy

Behaviour:
Reset (rst=0, async) values:
- ready=0, o_data=0, frame_end=0, overflow=0, sof_err=0, level=0.
- Pack lane counter=0, frame word counter=0, FIFO pointers=0.

Packer:
- 2-bit lane counter. Each pix_valid writes pix_data into lane[cnt], then cnt++.
- On lane 3 the full word (including the current pixel) is presented as a push the same cycle; the counter wraps to 0.
- pix_valid && sof: forces this pixel into lane 0 and clears the frame word counter.
  - If the lane counter was not 0, or the frame word counter was not 0 (incomplete frame), the partial data is discarded and sof_err is set.
  - Words already in the FIFO are kept.
- pix_valid=0: no state change.

Frame counter:
- Increments on each push attempt, whether accepted or dropped.
- When it reaches FRAME_PIX/4: frame_end pulses for 1 cycle (the cycle after the push edge) and the counter wraps to 0.
- Pixels after frame completion without sof begin a new frame implicitly.

FIFO (FWFT):
- o_data reflects the head word combinationally from storage; ready = (level != 0).
- Pop when request && ready. A request while ready=0 is ignored.
- Push accepted when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle.
- Push while full with no pop: the word is dropped and overflow is set (sticky until reset).
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Push into an empty FIFO: ready rises on the next cycle. Latency from the 4th pixel to ready=1 is 1 cycle.
- Pointers wrap modulo DEPTH; level is the separate full/empty discriminator.

Mid-operation reset:
- Asynchronously clears all state, including FIFO contents (logically, via pointers/level).
- Packed data in flight is lost; no pulse is emitted.

Decomposition:
- Shared package (hog_pkg): PIX_W, IN_W=PIX_W*4, and the frame geometry constants (width 160, height 120, FRAME_PIX). These are shared with the hog block.
- One natural sub-module: sync_fifo_fwft (params DW, DEPTH; ports push, din, pop, dout, empty, full, level). It is reusable by the svm result path.
- The packer, frame counter and sticky flags stay in the top module.

Test Plan:
1. Reset, then 4 pixels 0x11,0x22,0x33,0x44 with sof on the first and request=0 -> o_data=0x44332211, ready=1 one cycle after the 4th pixel, level=1.
2. Push 20 words with request=0 (DEPTH=16) -> level=16, overflow=1 after the 17th word. Then pop all -> 16 words in order, the first 16 groups, and ready=0 afterwards.
3. Full FIFO, request=1 held while the 4th pixel of a new group arrives -> push accepted, level stays 16, overflow unchanged (0).
4. 6 pixels, then sof with pixel 0xAA followed by 3 more pixels -> sof_err=1; the FIFO holds word 1 then a word with 0xAA in the low byte; the 2 stray pixels are discarded.
5. With FRAME_PIX=16 override, stream 16 pixels -> frame_end pulses exactly once, on the cycle after the 4th push. A 17th..20th pixel group without sof -> a new frame counts, no sof_err.
6. Assert rst=0 mid-stream with level=5 and lane=2 -> all outputs 0 immediately. After release, 4 pixels produce a correctly aligned word.
